psum_buffer: RTL

// Partial-sum store on the return side of the MAC array. Captures each lane's 33-bit result on

---
 rtl/psum_buffer_if.sv | 48 ++++
 rtl/psum_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/psum_buffer_if.sv
// -----------------------------------------------------------------------------
// psum_buffer_if
// Bundles the job-control, MAC-side and drain-side signals of the partial-sum
// buffer. The master side is the MAC array plus its controller and the
// downstream consumer. The slave side is the buffer.
//
// Signals (LANES lanes; PW = $clog2(DEPTH))
//   start                   job start request, sampled only while idle
//   cfg_pos   [PW:0]        positions per pass (1..DEPTH), latched at start
//   cfg_pass  [7:0]         accumulation passes (1..255), latched at start
//   partial_output_prepare  MAC asks for the C operand of the next position
//   result_vld              MAC result valid this cycle
//   result    [LANES*33]    MAC results, lane i at [i*33 +: 33]
//   partial_output [LANES*28] C operands, lane i at [i*28 +: 28]
//   out_vld / out_rdy       drain handshake
//   out_data  [LANES*28]    finished sums of the current drain position
//   busy, done, err         status
// -----------------------------------------------------------------------------
interface psum_buffer_if #(
    parameter int LANES = 120,
    parameter int DEPTH = 32
);
    localparam int PW = $clog2(DEPTH);

    logic                  start;
    logic [PW:0]           cfg_pos;
    logic [7:0]            cfg_pass;
    logic                  partial_output_prepare;
    logic                  result_vld;
    logic [LANES*33-1:0]   result;
    logic [LANES*28-1:0]   partial_output;
    logic                  out_vld;
    logic                  out_rdy;
    logic [LANES*28-1:0]   out_data;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, cfg_pos, cfg_pass, partial_output_prepare, result_vld, result, out_rdy,
        input  partial_output, out_vld, out_data, busy, done, err
    );

    modport slave (
        input  start, cfg_pos, cfg_pass, partial_output_prepare, result_vld, result, out_rdy,
        output partial_output, out_vld, out_data, busy, done, err
    );
endinterface

// File: rtl/psum_buffer.sv
// -----------------------------------------------------------------------------
// psum_buffer
// Partial-sum store on the return side of the MAC array. Each lane's 33-bit
// MAC result is narrowed to 28 bits and written into a per-lane RAM entry
// (one wide word per output position). On a prepare request the stored sum of
// the next position is handed back as the MAC C operand (zero on pass 0).
// After the final pass the finished sums are drained over valid/ready.
//
// Ports
//   clk   clock, everything on posedge
//   rst   synchronous active-high reset (aborts a running job)
//   bus   psum_buffer_if.slave: start/cfg, prepare/result, partial_output,
//         out_vld/out_rdy/out_data, busy/done/err
//
// Build option
//   PSUM_SAT_EN  when defined, narrowing saturates to the 28-bit signed range;
//                otherwise it is a plain two's-complement truncation.
// -----------------------------------------------------------------------------
module psum_buffer #(
    parameter int LANES = 120,   // `MAC_NUM in the array build
    parameter int DEPTH = 32
) (
    input logic           clk,
    input logic           rst,
    psum_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int RW = 33;
    localparam int SW = 28;

`ifdef PSUM_SAT_EN
    localparam logic signed [RW-1:0] SAT_MAX = 33'sh0_07FF_FFFF;
    localparam logic signed [RW-1:0] SAT_MIN = 33'sh1_F800_0000;
`endif

    function automatic logic [SW-1:0] narrow(input logic signed [RW-1:0] r);
`ifdef PSUM_SAT_EN
        if (r > SAT_MAX) return 28'h7FF_FFFF;
        if (r < SAT_MIN) return 28'h800_0000;
`endif
        return r[SW-1:0];
    endfunction

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t               state;
    logic [PW:0]          last_pos;
    logic [7:0]           last_pass;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        drain_ptr;
    logic [7:0]           rd_pass;
    logic [7:0]           wr_pass;
    logic [LANES*SW-1:0]  mem [DEPTH];
    logic [LANES*SW-1:0]  narrowed;
    logic [LANES*SW-1:0]  partial_p1;
    logic [LANES*SW-1:0]  drain_data_p1;
    logic                 drain_vld_p1;
    logic                 done_q;
    logic                 err_q;
    logic [PW:0]          pos_eff;
    logic [PW-1:0]        drain_nxt;
    logic                 rd_wrap;
    logic                 wr_wrap;
    logic                 drain_wrap;
    logic                 prep;
    logic                 rvld;

    assign prep       = bus.partial_output_prepare;
    assign rvld       = bus.result_vld;
    assign drain_nxt  = drain_ptr + 1'b1;
    assign rd_wrap    = ({1'b0, rd_ptr} == last_pos);
    assign wr_wrap    = ({1'b0, wr_ptr} == last_pos);
    assign drain_wrap = ({1'b0, drain_ptr} == last_pos);

    // A zero position count runs as one position; anything above DEPTH is
    // clamped so the pointers always reach their wrap value.
    always_comb begin
        pos_eff = bus.cfg_pos;
        if (bus.cfg_pos == '0)
            pos_eff = (PW+1)'(1);
        else if (bus.cfg_pos > (PW+1)'(DEPTH))
            pos_eff = (PW+1)'(DEPTH);
    end

    always_comb begin
        narrowed = '0;
        for (int i = 0; i < LANES; i++)
            narrowed[i*SW +: SW] = narrow($signed(bus.result[i*RW +: RW]));
    end

    // ---- stage p0 -> p1: RAM write (contents are not reset) ----
    always_ff @(posedge clk) begin
        if (state == ACCUM && rvld)
            mem[wr_ptr] <= narrowed;
    end

    // ---- stage p0 -> p1: control FSM, C-operand read and drain read ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_pos      <= '0;
            last_pass     <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            drain_ptr     <= '0;
            rd_pass       <= '0;
            wr_pass       <= '0;
            partial_p1    <= '0;
            drain_data_p1 <= '0;
            drain_vld_p1  <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((prep || rvld) && state != ACCUM)
                err_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        last_pos  <= pos_eff - 1'b1;
                        last_pass <= (bus.cfg_pass == 8'd0) ? 8'd0 : bus.cfg_pass - 8'd1;
                        rd_ptr    <= '0;
                        wr_ptr    <= '0;
                        rd_pass   <= '0;
                        wr_pass   <= '0;
                        drain_ptr <= '0;
                        state     <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (prep) begin
                        // The same-cycle write is not yet visible in the RAM,
                        // so a read of the entry being written takes the
                        // incoming result directly.
                        if (rd_pass == 8'd0)
                            partial_p1 <= '0;
                        else if (rvld && rd_ptr == wr_ptr)
                            partial_p1 <= narrowed;
                        else
                            partial_p1 <= mem[rd_ptr];
                        if (rd_wrap) begin
                            rd_ptr  <= '0;
                            rd_pass <= rd_pass + 8'd1;
                        end else begin
                            rd_ptr  <= rd_ptr + 1'b1;
                        end
                    end
                    if (rvld) begin
                        if (wr_wrap) begin
                            wr_ptr  <= '0;
                            wr_pass <= wr_pass + 8'd1;
                            if (wr_pass == last_pass) begin
                                drain_ptr <= '0;
                                state     <= DRAIN;
                            end
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    // One load cycle on entry, then back-to-back beats: the
                    // next word is fetched in the same cycle a beat is taken.
                    if (!drain_vld_p1) begin
                        drain_data_p1 <= mem[drain_ptr];
                        drain_vld_p1  <= 1'b1;
                    end else if (bus.out_rdy) begin
                        if (drain_wrap) begin
                            drain_vld_p1 <= 1'b0;
                            done_q       <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            drain_ptr     <= drain_nxt;
                            drain_data_p1 <= mem[drain_nxt];
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.partial_output = partial_p1;
    assign bus.out_data       = drain_data_p1;
    assign bus.out_vld        = drain_vld_p1;
    assign bus.busy           = (state != IDLE);
    assign bus.done           = done_q;
    assign bus.err            = err_q;
endmodule
